// File: rtl/dac_frame_sequencer.sv
// dac_frame_sequencer: walks NUM_SLOTS channel slots per frame (4 states each) and
// presents one selected amplifier sample to the DAC, refreshed at each frame end.
module dac_frame_sequencer #(
    parameter int NUM_SLOTS = 20
) (
    input  logic        dataclk,
    input  logic        reset,
    input  logic        run,
    input  logic [5:0]  DAC_channel_sel,
    input  logic [15:0] data_in,
    input  logic        data_in_valid,
    output logic [31:0] main_state,
    output logic [5:0]  channel,
    output logic        sample_clk,
    output logic [15:0] DAC_input,
    output logic        DAC_input_valid,
    output logic        sample_missing,
    output logic [31:0] frame_count,
    output logic        busy
);
    typedef enum logic [7:0] {
        S_IDLE = 8'd99,
        S_A    = 8'd100,
        S_B    = 8'd135,
        S_C    = 8'd170,
        S_D    = 8'd205
    } state_t;

    localparam logic [5:0] LAST = 6'(NUM_SLOTS - 1);

    state_t      state_q;
    logic [5:0]  channel_q;
    logic [5:0]  sel_q;
    logic [15:0] hold_q;
    logic        cap_q;
    logic        sample_clk_q;
    logic [15:0] dac_q;
    logic        dac_valid_q;
    logic        missing_q;
    logic [31:0] frame_count_q;
    logic        cap_d;
    logic        frame_end_d;

    // channel never reaches NUM_SLOTS, so an out-of-range sel_q simply never matches
    assign cap_d       = data_in_valid && (state_q != S_IDLE) && (channel_q == sel_q);
    assign frame_end_d = (state_q == S_D) && (channel_q == LAST);

    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            channel_q     <= '0;
            sel_q         <= '0;
            hold_q        <= '0;
            cap_q         <= 1'b0;
            sample_clk_q  <= 1'b0;
            dac_q         <= '0;
            dac_valid_q   <= 1'b0;
            missing_q     <= 1'b0;
            frame_count_q <= '0;
        end else begin
            dac_valid_q <= 1'b0;
            missing_q   <= 1'b0;
            if (cap_d) begin
                hold_q <= data_in;
                cap_q  <= 1'b1;
            end
            case (state_q)
                S_IDLE: if (run) begin
                    state_q      <= S_A;
                    channel_q    <= '0;
                    sel_q        <= DAC_channel_sel;
                    sample_clk_q <= 1'b1;
                end
                S_A: state_q <= S_B;
                S_B: state_q <= S_C;
                S_C: state_q <= S_D;
                S_D: begin
                    sample_clk_q <= 1'b0;
                    if (frame_end_d) begin
                        state_q       <= S_IDLE;
                        channel_q     <= '0;
                        frame_count_q <= frame_count_q + 32'd1;
                        cap_q         <= 1'b0;
                        // a capture on this same edge still belongs to the ending frame
                        if (cap_q || cap_d) begin
                            dac_q       <= cap_d ? data_in : hold_q;
                            dac_valid_q <= 1'b1;
                        end else begin
                            missing_q <= 1'b1;
                        end
                    end else begin
                        state_q   <= S_A;
                        channel_q <= channel_q + 6'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign main_state      = {24'd0, state_q};
    assign channel         = channel_q;
    assign sample_clk      = sample_clk_q;
    assign DAC_input       = dac_q;
    assign DAC_input_valid = dac_valid_q;
    assign sample_missing  = missing_q;
    assign frame_count     = frame_count_q;
    assign busy            = state_q != S_IDLE;
endmodule

// File: tb/tb_dac_frame_sequencer.sv
// tb_dac_frame_sequencer: randomized and directed stimulus against a frame-position
// reference model; a monitor compares DUT outputs to queued expectations every cycle.
module tb_dac_frame_sequencer;
    localparam int N = 20;

    logic        dataclk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [5:0]  DAC_channel_sel = '0;
    logic [15:0] data_in = '0;
    logic        data_in_valid = 1'b0;
    logic [31:0] main_state;
    logic [5:0]  channel;
    logic        sample_clk;
    logic [15:0] DAC_input;
    logic        DAC_input_valid;
    logic        sample_missing;
    logic [31:0] frame_count;
    logic        busy;

    dac_frame_sequencer #(.NUM_SLOTS(N)) dut (
        .dataclk(dataclk), .reset(reset), .run(run), .DAC_channel_sel(DAC_channel_sel),
        .data_in(data_in), .data_in_valid(data_in_valid), .main_state(main_state),
        .channel(channel), .sample_clk(sample_clk), .DAC_input(DAC_input),
        .DAC_input_valid(DAC_input_valid), .sample_missing(sample_missing),
        .frame_count(frame_count), .busy(busy)
    );

    always #5 dataclk = ~dataclk;

    typedef struct {
        logic [31:0] st;
        logic [5:0]  ch;
        logic        sc;
        logic        bsy;
        logic [31:0] fc;
        logic [15:0] dac;
        logic        dv;
        logic        miss;
    } exp_t;

    typedef struct {
        logic        valid;
        logic [15:0] dac;
    } ev_t;

    exp_t exp_q[$];
    ev_t  ev_q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model: position within the frame (-1 = gap/idle, else 0..4N-1)
    int          m_pos = -1;
    int          m_sel = 0;
    logic [15:0] m_hold = '0;
    bit          m_cap = 0;
    logic [15:0] m_dac = '0;
    logic [31:0] m_fc = '0;
    int          codes[4] = '{100, 135, 170, 205};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [5:0] s, input logic [15:0] d,
                        input logic v, input logic rs);
        exp_t e;
        bit   fe;
        bit   capt;
        run = r;
        DAC_channel_sel = s;
        data_in = d;
        data_in_valid = v;
        if (rs && !reset) begin
            reset = 1'b1;
            #1;
            chk("rst_state", main_state, 32'd99);
            chk("rst_channel", {26'd0, channel}, 32'd0);
            chk("rst_fc", frame_count, 32'd0);
            chk("rst_pulses", {30'd0, DAC_input_valid, sample_missing}, 32'd0);
        end
        reset = rs;
        e.dv = 0;
        e.miss = 0;
        if (rs) begin
            m_pos = -1; m_sel = 0; m_hold = '0; m_cap = 0; m_dac = '0; m_fc = '0;
        end else begin
            capt = v && m_pos >= 0 && (m_pos / 4) == m_sel;
            fe = m_pos == 4 * N - 1;
            if (capt) begin
                m_hold = d;
                m_cap = 1;
            end
            if (m_pos < 0) begin
                if (r) begin
                    m_pos = 0;
                    m_sel = int'(s);
                end
            end else if (fe) begin
                m_pos = -1;
                m_fc++;
                if (m_cap) m_dac = m_hold;
                e.dv = m_cap;
                e.miss = !m_cap;
                ev_q.push_back('{valid: m_cap, dac: m_hold});
                m_cap = 0;
            end else begin
                m_pos++;
            end
        end
        e.st  = m_pos < 0 ? 32'd99 : 32'(codes[m_pos % 4]);
        e.ch  = m_pos < 0 ? 6'd0 : 6'(m_pos / 4);
        e.sc  = m_pos >= 0 && m_pos < 4;
        e.bsy = m_pos >= 0;
        e.fc  = m_fc;
        e.dac = m_dac;
        exp_q.push_back(e);
        @(negedge dataclk);
    endtask

    always @(posedge dataclk) begin
        exp_t e;
        ev_t  v;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("main_state", main_state, e.st);
            chk("channel", {26'd0, channel}, {26'd0, e.ch});
            chk("sample_clk", {31'd0, sample_clk}, {31'd0, e.sc});
            chk("busy", {31'd0, busy}, {31'd0, e.bsy});
            chk("frame_count", frame_count, e.fc);
            chk("DAC_input", {16'd0, DAC_input}, {16'd0, e.dac});
            chk("pulses", {30'd0, DAC_input_valid, sample_missing}, {30'd0, e.dv, e.miss});
        end
        if (DAC_input_valid || sample_missing) begin
            if (ev_q.size() == 0) begin
                chk("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                v = ev_q.pop_front();
                chk("ev_kind", {31'd0, DAC_input_valid}, {31'd0, v.valid});
                if (v.valid) chk("ev_data", {16'd0, DAC_input}, {16'd0, v.dac});
            end
        end
    end

    task automatic go_idle();
        int guard = 0;
        while (m_pos != -1 && guard < 4 * N + 4) begin
            step(0, 6'd0, 16'(($urandom)), 0, 0);
            guard++;
        end
        if (m_pos != -1) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        repeat (3) step(0, 6'd0, 16'd0, 0, 1);
        // continuous run with random capture traffic
        repeat (4 * (4 * N + 1)) step(1, 6'($urandom_range(0, 23)), 16'($urandom),
                                      ($urandom_range(0, 7) == 0), 0);
        go_idle();
        // capture in slot 3 state 135, then a frame without capture
        step(1, 6'd3, 16'd0, 0, 0);
        repeat (4 * N) step(0, 6'd7, m_pos == 13 ? 16'h1234 : 16'($urandom), m_pos == 13, 0);
        step(1, 6'd3, 16'd0, 0, 0);
        repeat (4 * N) step(0, 6'd3, 16'($urandom), 0, 0);
        // select change mid-frame is ignored; next frame captures slot 5
        step(1, 6'd3, 16'd0, 0, 0);
        repeat (4 * N) step(0, m_pos >= 8 ? 6'd5 : 6'd3, 16'($urandom), (m_pos / 4) == 5, 0);
        step(1, 6'd5, 16'd0, 0, 0);
        repeat (4 * N) step(0, 6'd5, 16'($urandom), (m_pos / 4) == 5, 0);
        // out-of-range select never captures
        step(1, 6'd63, 16'd0, 0, 0);
        repeat (4 * N) step(0, 6'd63, 16'($urandom), 1, 0);
        // run dropped in slot 10
        step(1, 6'd0, 16'd0, 0, 0);
        repeat (4 * N) step(m_pos < 40, 6'd0, 16'($urandom), 0, 0);
        repeat (10) step(0, 6'd0, 16'd0, 1, 0);
        // reset in slot 7 state 170
        step(1, 6'd7, 16'd0, 0, 0);
        while (m_pos != 30) step(1, 6'd7, 16'hAAAA, 1, 0);
        step(1, 6'd7, 16'd0, 0, 1);
        step(0, 6'd0, 16'd0, 0, 1);
        step(0, 6'd0, 16'd0, 0, 0);
        // frame_count wrap
        force dut.frame_count_q = 32'hFFFF_FFFF;
        #1 release dut.frame_count_q;
        m_fc = 32'hFFFF_FFFF;
        step(1, 6'd1, 16'd0, 0, 0);
        repeat (4 * N) step(0, 6'd1, 16'h5A5A, 1, 0);
        // long random run with occasional resets
        repeat (3000) step($urandom_range(0, 9) != 0, 6'($urandom_range(0, 23)), 16'($urandom),
                           ($urandom_range(0, 5) == 0), ($urandom_range(0, 299) == 0));
        repeat (4 * N + 3) step(0, 6'd0, 16'd0, 0, 0);
        chk("events_drained", ev_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dac_frame_sequencer.md
DAC_FRAME_SEQUENCER -- requirements
Module: dac_frame_sequencer

Interface
REQ-001 Parameter: NUM_SLOTS, 20, channel slots per frame (16 amplifier plus 4 auxiliary); legal range 2..64.
REQ-002 Port: dataclk  in  1  sole clock; all state updates on its rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high; forces all registers to reset values immediately.
REQ-004 Port: run  in  1  level; frames start only while high.
REQ-005 Port: DAC_channel_sel  in  6  slot index whose sample feeds the DAC.
REQ-006 Port: data_in  in  16  amplifier sample for the current slot.
REQ-007 Port: data_in_valid  in  1  qualifies data_in.
REQ-008 Port: main_state  out  32  registered state code: 99, 100, 135, 170 or 205.
REQ-009 Port: channel  out  6  registered current slot index.
REQ-010 Port: sample_clk  out  1  registered frame marker.
REQ-011 Port: DAC_input  out  16  registered sample, stable for a whole frame.
REQ-012 Port: DAC_input_valid  out  1  one-cycle pulse when DAC_input updates.
REQ-013 Port: sample_missing  out  1  one-cycle pulse when a frame ends with no capture.
REQ-014 Port: frame_count  out  32  completed frames, wraps 2^32-1 to 0.
REQ-015 Port: busy  out  1  high whenever main_state != 99.

Function
REQ-016 Each state lasts exactly one dataclk cycle; the per-slot sequence is 100 -> 135 -> 170 -> 205.
REQ-017 From 99: run=1 sampled -> next state 100 with channel=0; run=0 -> stay 99.
REQ-018 From 205 with channel < NUM_SLOTS-1 -> 100 with channel+1, regardless of run.
REQ-019 From 205 with channel = NUM_SLOTS-1 -> 99 with channel=0 (one-cycle frame gap); continuous-run frame period = 4*NUM_SLOTS+1 cycles (81 at default).
REQ-020 run deasserted mid-frame has no effect until the frame completes; the sequencer then idles in 99.
REQ-021 DAC_channel_sel latches into sel_q on the 99 -> 100 transition only; mid-frame changes are ignored.
REQ-022 Capture: data_in is written to an internal hold register and a capture flag is set when data_in_valid=1, main_state != 99, and channel = sel_q.
REQ-023 Multiple captures in one frame: the last one wins.
REQ-024 sel_q >= NUM_SLOTS never captures.
REQ-025 sample_clk is 1 during all four states of slot 0 and 0 otherwise.
REQ-026 Frame end is the 205 -> 99 edge of the last slot. On that edge:
- frame_count increments by 1.
- If the capture flag is set: DAC_input takes the hold value and DAC_input_valid=1 for the following cycle.
- If the capture flag is clear: DAC_input holds and sample_missing=1 for the following cycle.
- The capture flag clears.
REQ-027 A capture in the last slot's state 205 (same edge as frame end) counts for the current frame.
REQ-028 data_in_valid while main_state=99 is ignored.

Reset
REQ-029 While reset=1, outputs take these values:
- main_state=99, channel=0.
- sample_clk=0, DAC_input=0, DAC_input_valid=0, sample_missing=0.
- frame_count=0, busy=0.
- Hold register and capture flag cleared; sel_q=0.
REQ-030 Reset asserted mid-frame aborts the frame with no pulses and no count.
REQ-031 After reset release, the sequence resumes per REQ-017 on the first rising edge with run=1.

Verification
REQ-032 run=1 continuously, NUM_SLOTS=20:
- main_state follows 99,100,135,170,205 repeating.
- channel runs 0..19.
- Frame period is 81 cycles.
- sample_clk is high for 4 cycles per frame.
REQ-033 Capture and stable output:
- Stimulus: sel=3; data_in=16'h1234 with valid in slot 3 state 135.
- Response: DAC_input=16'h1234 after frame end, with a one-cycle DAC_input_valid.
- DAC_input stays constant through the whole next frame.
REQ-034 Mid-frame select change and no capture:
- Stimulus: sel changed 3 -> 5 in slot 2; valid asserted only in slot 5.
- Response: no capture; sample_missing pulses; DAC_input unchanged.
- The next frame captures from slot 5.
REQ-035 Stop at frame end: run dropped in slot 10 -> frame completes, main_state holds at 99, busy=0, frame_count increments once.
REQ-036 Reset mid-frame: reset asserted in slot 7 state 170 -> immediately main_state=99, channel=0, frame_count=0, no pulses.
REQ-037 Wrap-around: frame_count preset via force to 32'hFFFFFFFF -> one completed frame gives 0.
